// File: rtl/eq_pkg.sv
// Shared types, constants and saturation helper for the three-band EQ sequencer.
package eq_pkg;

    localparam int unsigned TAPS   = 5;
    localparam int unsigned NBANDS = 3;
    localparam int unsigned SAT_W  = 40;

    localparam logic [2:0] TAP_X0 = 3'd0;
    localparam logic [2:0] TAP_X1 = 3'd1;
    localparam logic [2:0] TAP_X2 = 3'd2;
    localparam logic [2:0] TAP_Y1 = 3'd3;
    localparam logic [2:0] TAP_Y2 = 3'd4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t MAC  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [SAT_W-1:0] v);
        if (v > 40'sd32767)
            return 16'sh7fff;
        else if (v < -40'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/eq_mac_unit.sv
// Shared multiply-accumulate: rounding preset, signed product, and
// round/shift/saturate view of the running sum.
module eq_mac_unit
    import eq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     preset,
    input  logic signed [DATA_W-1:0] operand,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [DATA_W-1:0] result_c
);

    logic signed [ACC_W-1:0]         acc;
    logic signed [ACC_W-1:0]         base_c;
    logic signed [ACC_W-1:0]         sum_c;
    logic signed [ACC_W-1:0]         shifted_c;
    logic signed [DATA_W+COEF_W-1:0] prod_c;

    // The preset injects half an LSB so the arithmetic shift rounds half up.
    always_comb begin
        prod_c    = operand * coef;
        base_c    = preset ? (ACC_W'(1) << (FRAC - 1)) : acc;
        sum_c     = base_c + ACC_W'(prod_c);
        shifted_c = sum_c >>> FRAC;
        result_c  = sat16(SAT_W'(shifted_c));
    end

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= sum_c;
    end

endmodule

// File: rtl/eq_mac_scheduler.sv
// Time-multiplexed biquad sequencer: 15 MACs per sample across three bands,
// then a saturated mix of the band outputs.
module eq_mac_scheduler
    import eq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic [3:0]               coef_addr_o,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] low_o,
    output logic signed [DATA_W-1:0] mid_o,
    output logic signed [DATA_W-1:0] high_o,
    output logic signed [DATA_W-1:0] mix_o,
    output logic                     out_valid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    state_t     state, state_nxt;
    logic [1:0] band, band_nxt;
    logic [2:0] tap, tap_nxt;

    logic signed [DATA_W-1:0] x0, x1, x2;
    logic signed [DATA_W-1:0] y1 [NBANDS];
    logic signed [DATA_W-1:0] y2 [NBANDS];
    logic signed [DATA_W-1:0] y1_sel_c, y2_sel_c;
    logic signed [DATA_W-1:0] operand_c;
    logic signed [DATA_W-1:0] result_c;
    logic signed [DATA_W+1:0] mix_sum_c;
    logic signed [DATA_W-1:0] mix_c;
    logic                     mac_en_c;
    logic                     band_done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            band  <= '0;
            tap   <= '0;
        end else begin
            state <= state_nxt;
            band  <= band_nxt;
            tap   <= tap_nxt;
        end
    end

    // Next-state sequencing and coefficient address decode.
    always_comb begin
        state_nxt   = state;
        band_nxt    = band;
        tap_nxt     = tap;
        coef_addr_o = 4'd0;
        case (state)
            IDLE: begin
                if (sample_valid_i) begin
                    state_nxt = MAC;
                    band_nxt  = 2'd0;
                    tap_nxt   = TAP_X0;
                end
            end
            MAC: begin
                coef_addr_o = 4'({2'b00, band} * 4'd5 + {1'b0, tap});
                if (tap == 3'(TAPS - 1)) begin
                    tap_nxt = TAP_X0;
                    if (band == 2'(NBANDS - 1))
                        state_nxt = DONE;
                    else
                        band_nxt = band + 2'd1;
                end else begin
                    tap_nxt = tap + 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand select; feedback history is per band, input history is shared.
    always_comb begin
        y1_sel_c = '0;
        y2_sel_c = '0;
        for (int b = 0; b < NBANDS; b++) begin
            if (band == 2'(b)) begin
                y1_sel_c = y1[b];
                y2_sel_c = y2[b];
            end
        end
        case (tap)
            TAP_X0:  operand_c = x0;
            TAP_X1:  operand_c = x1;
            TAP_X2:  operand_c = x2;
            TAP_Y1:  operand_c = y1_sel_c;
            TAP_Y2:  operand_c = y2_sel_c;
            default: operand_c = '0;
        endcase
    end

    assign mac_en_c    = (state == MAC);
    assign band_done_c = mac_en_c && (tap == TAP_Y2);

    eq_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (mac_en_c),
        .preset   (tap == TAP_X0),
        .operand  (operand_c),
        .coef     (coef_i),
        .result_c (result_c)
    );

    assign mix_sum_c = (DATA_W+2)'(low_o) + (DATA_W+2)'(mid_o) + (DATA_W+2)'(high_o);
    assign mix_c     = sat16(SAT_W'(mix_sum_c));

    always_ff @(posedge clk) begin
        if (reset) begin
            x0          <= '0;
            x1          <= '0;
            x2          <= '0;
            low_o       <= '0;
            mid_o       <= '0;
            high_o      <= '0;
            mix_o       <= '0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
            for (int b = 0; b < NBANDS; b++) begin
                y1[b] <= '0;
                y2[b] <= '0;
            end
        end else begin
            out_valid_o <= (state == DONE);
            // Busy also covers the output-valid cycle after DONE.
            busy_o      <= (state_nxt != IDLE) || (state == DONE);
            if (sample_valid_i && (state != IDLE))
                overrun_o <= 1'b1;
            if ((state == IDLE) && sample_valid_i)
                x0 <= sample_i;
            for (int b = 0; b < NBANDS; b++) begin
                if (band_done_c && (band == 2'(b))) begin
                    y2[b] <= y1[b];
                    y1[b] <= result_c;
                end
            end
            if (band_done_c) begin
                case (band)
                    2'd0:    low_o  <= result_c;
                    2'd1:    mid_o  <= result_c;
                    default: high_o <= result_c;
                endcase
            end
            if (state == DONE) begin
                mix_o <= mix_c;
                x2    <= x1;
                x1    <= x0;
            end
        end
    end

endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Directed, table-driven bench for the three-band EQ MAC sequencer.
module tb_eq_mac_scheduler;

    logic               clk;
    logic               reset;
    logic               sample_valid_i;
    logic signed [15:0] sample_i;
    logic [3:0]         coef_addr_o;
    logic signed [15:0] coef_i;
    logic signed [15:0] low_o, mid_o, high_o, mix_o;
    logic               out_valid_o, busy_o, overrun_o;

    logic signed [15:0] coef_mem [16];
    int errors = 0;
    int checks = 0;

    assign coef_i = coef_mem[coef_addr_o];

    eq_mac_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .coef_addr_o    (coef_addr_o),
        .coef_i         (coef_i),
        .low_o          (low_o),
        .mid_o          (mid_o),
        .high_o         (high_o),
        .mix_o          (mix_o),
        .out_valid_o    (out_valid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit fresh;
        int a0, v0, a1, v1, a2, v2;
        int x;
        int lo, mi, hi, mx;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_coefs(input vec_t v);
        for (int i = 0; i < 16; i++) coef_mem[i] = 16'sd0;
        coef_mem[v.a0] = 16'(v.v0);
        coef_mem[v.a1] = 16'(v.v1);
        coef_mem[v.a2] = 16'(v.v2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_low"}, low_o, 0);
        chk({tag, "_mid"}, mid_o, 0);
        chk({tag, "_high"}, high_o, 0);
        chk({tag, "_mix"}, mix_o, 0);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_overrun"}, overrun_o, 0);
        chk({tag, "_addr"}, coef_addr_o, 0);
    endtask

    // One sample through the pipe, checking busy, address sweep and latency.
    task automatic run_sample(input logic signed [15:0] s);
        int lat;
        lat = 0;
        @(negedge clk);
        sample_valid_i = 1'b1;
        sample_i       = s;
        @(posedge clk);
        #1;
        chk("busy_e0", busy_o, 1);
        @(negedge clk);
        sample_valid_i = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 14) chk("addr_e14", coef_addr_o, 14);
            if (out_valid_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, 16);
        chk("busy_e16", busy_o, 1);
        @(posedge clk);
        #1;
        chk("valid_e17", out_valid_o, 0);
        chk("busy_e17", busy_o, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        vec_t v;
        reset          = 1'b1;
        sample_valid_i = 1'b0;
        sample_i       = '0;
        for (int i = 0; i < 16; i++) coef_mem[i] = 16'sd0;

        //            fresh a0  v0      a1  v1      a2  v2      x       lo      mi      hi      mx
        vecs[0]  = '{1, 0, 16384, 15, 0,     15, 0,     1000,   1000,   0,      0,      1000};
        vecs[1]  = '{1, 6, 16384, 15, 0,     15, 0,     500,    0,      0,      0,      0};
        vecs[2]  = '{0, 6, 16384, 15, 0,     15, 0,     0,      0,      500,    0,      500};
        vecs[3]  = '{1, 0, 16384, 3,  8192,  15, 0,     1000,   1000,   0,      0,      1000};
        vecs[4]  = '{0, 0, 16384, 3,  8192,  15, 0,     0,      500,    0,      0,      500};
        vecs[5]  = '{0, 0, 16384, 3,  8192,  15, 0,     0,      250,    0,      0,      250};
        vecs[6]  = '{0, 0, 16384, 3,  8192,  15, 0,     0,      125,    0,      0,      125};
        vecs[7]  = '{0, 0, 16384, 3,  8192,  15, 0,     0,      63,     0,      0,      63};
        vecs[8]  = '{1, 0, 16384, 5,  16384, 10, 16384, 20000,  20000,  20000,  20000,  32767};
        vecs[9]  = '{0, 0, 16384, 5,  16384, 10, 16384, -20000, -20000, -20000, -20000, -32768};
        vecs[10] = '{1, 0, 32767, 15, 0,     15, 0,     30000,  32767,  0,      0,      32767};
        vecs[11] = '{1, 0, -16384, 15, 0,    15, 0,     1000,   -1000,  0,      0,      -1000};
        vecs[12] = '{1, 0, 8192,  5,  16384, 10, -4096, 3000,   1500,   3000,   -750,   3750};

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("por");

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.fresh) begin
                reset_dut();
                load_coefs(v);
            end
            run_sample(16'(v.x));
            chk($sformatf("v%0d_low", i), low_o, v.lo);
            chk($sformatf("v%0d_mid", i), mid_o, v.mi);
            chk($sformatf("v%0d_high", i), high_o, v.hi);
            chk($sformatf("v%0d_mix", i), mix_o, v.mx);
        end

        // Overrun: second strobe at E5 is dropped and flagged.
        reset_dut();
        load_coefs(vecs[0]);
        chk("ovr_pre", overrun_o, 0);
        @(negedge clk);
        sample_valid_i = 1'b1;
        sample_i       = 16'sd1000;
        @(posedge clk);
        @(negedge clk);
        sample_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        sample_valid_i = 1'b1;
        sample_i       = 16'sd7777;
        @(posedge clk);
        #1;
        chk("ovr_set", overrun_o, 1);
        @(negedge clk);
        sample_valid_i = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("ovr_latency", lat, 11);
        chk("ovr_low", low_o, 1000);
        chk("ovr_mix", mix_o, 1000);
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid_o === 1'b1) pulses++;
        end
        chk("ovr_no_second", pulses, 0);
        chk("ovr_sticky", overrun_o, 1);
        chk("ovr_low_hold", low_o, 1000);
        reset_dut();
        #1;
        chk("ovr_clr", overrun_o, 0);

        // Reset at E8 mid-sample clears outputs and history.
        load_coefs(vecs[3]);
        run_sample(16'sd1000);
        chk("mid_rst_pre_low", low_o, 1000);
        @(negedge clk);
        sample_valid_i = 1'b1;
        sample_i       = 16'sd0;
        @(posedge clk);
        @(negedge clk);
        sample_valid_i = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("e8");
        @(negedge clk);
        reset = 1'b0;
        coef_mem[1] = 16'sd16384;
        run_sample(16'sd0);
        chk("e8_hist_low", low_o, 0);
        chk("e8_hist_mix", mix_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
